// File: rtl/spi_flash_responder_if.sv
// Byte-wide read port between the SPI flash responder and its backing array.
// The responder drives the request side (master); the array answers (slave).
interface spi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rdata;
  logic              ack;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output ack
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder serving opcode CMD_READ + address + data stream.
// SPI pins are oversampled in the clock domain; nothing runs on spi_sck.
module spi_flash_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter int         ADDR_W      = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_ss,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  spi_flash_responder_if.master mem,
  output logic                  busy,
  output logic                  cmd_err,
  output logic                  underrun
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  localparam logic [5:0] LAST_ADDR_BIT = 6'(8 + ADDR_W - 1);
  // Chain reset values, index order {mosi, ss, sck}: ss idles high.
  localparam logic [2:0] SYNC_INIT = 3'b010;

  logic [2:0] spi_in;
  logic [2:0] spi_sync;

  assign spi_in = {spi_mosi, spi_ss, spi_sck};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          chain_reg <= {SYNC_STAGES{SYNC_INIT[gi]}};
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], spi_in[gi]};
        end
      end

      assign spi_sync[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic sck_s;
  logic ss_s;
  logic mosi_s;

  assign sck_s  = spi_sync[0];
  assign ss_s   = spi_sync[1];
  assign mosi_s = spi_sync[2];

  state_t            state_reg;
  logic [5:0]        bit_cnt_reg;
  logic [2:0]        byte_bit_reg;
  logic [7:0]        cmd_reg;
  logic [7:0]        tx_reg;
  logic [7:0]        pf_data_reg;
  logic              pf_valid_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              req_reg;
  logic              drop_reg;
  logic              need_req_reg;
  logic              load_pend_reg;
  logic              miso_reg;
  logic              busy_reg;
  logic              cmd_err_reg;
  logic              underrun_reg;
  logic              sck_d_reg;
  logic              ss_d_reg;

  logic              sck_rise;
  logic              sck_fall;
  logic              ss_rise;
  logic              ss_fall;
  logic              ack_hit;
  logic              load_now;
  logic [7:0]        opcode_next;
  logic [ADDR_W-1:0] addr_next;

  assign sck_rise    = sck_s & ~sck_d_reg;
  assign sck_fall    = ~sck_s & sck_d_reg;
  assign ss_rise     = ss_s & ~ss_d_reg;
  assign ss_fall     = ~ss_s & ss_d_reg;
  assign ack_hit     = mem.ack & req_reg;
  assign load_now    = (state_reg == DATA) & sck_fall & load_pend_reg & ~ss_rise;
  assign opcode_next = {cmd_reg[6:0], mosi_s};
  assign addr_next   = {addr_reg[ADDR_W-2:0], mosi_s};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      byte_bit_reg  <= '0;
      cmd_reg       <= '0;
      tx_reg        <= '0;
      pf_data_reg   <= '0;
      pf_valid_reg  <= 1'b0;
      addr_reg      <= '0;
      mem_addr_reg  <= '0;
      req_reg       <= 1'b0;
      drop_reg      <= 1'b0;
      need_req_reg  <= 1'b0;
      load_pend_reg <= 1'b0;
      miso_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      cmd_err_reg   <= 1'b0;
      underrun_reg  <= 1'b0;
      sck_d_reg     <= 1'b0;
      ss_d_reg      <= 1'b1;
    end else begin
      sck_d_reg    <= sck_s;
      ss_d_reg     <= ss_s;
      cmd_err_reg  <= 1'b0;
      underrun_reg <= 1'b0;

      if (ack_hit) begin
        req_reg <= 1'b0;
        if (drop_reg) begin
          drop_reg <= 1'b0;
        end else begin
          pf_data_reg  <= mem.rdata;
          pf_valid_reg <= 1'b1;
        end
      end

      // Deferred fetch: waits for the port to go idle, yields to a byte load.
      if (need_req_reg && !req_reg && !load_now) begin
        req_reg      <= 1'b1;
        mem_addr_reg <= addr_reg;
        need_req_reg <= 1'b0;
      end

      if (ss_rise) begin
        state_reg     <= IDLE;
        busy_reg      <= 1'b0;
        miso_reg      <= 1'b0;
        bit_cnt_reg   <= '0;
        byte_bit_reg  <= '0;
        load_pend_reg <= 1'b0;
        need_req_reg  <= 1'b0;
        pf_valid_reg  <= 1'b0;
        drop_reg      <= req_reg & ~ack_hit;
      end else begin
        case (state_reg)
          IDLE: begin
            miso_reg <= 1'b0;
            if (ss_fall) begin
              state_reg   <= CMD;
              busy_reg    <= 1'b1;
              bit_cnt_reg <= '0;
            end
          end

          CMD: begin
            if (sck_rise) begin
              cmd_reg     <= opcode_next;
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
              if (bit_cnt_reg == 6'd7) begin
                if (opcode_next == CMD_READ) begin
                  state_reg <= ADDR;
                end else begin
                  cmd_err_reg <= 1'b1;
                  state_reg   <= IGNORE;
                end
              end
            end
          end

          ADDR: begin
            if (sck_rise) begin
              addr_reg    <= addr_next;
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
              if (bit_cnt_reg == LAST_ADDR_BIT) begin
                state_reg     <= DATA;
                byte_bit_reg  <= '0;
                load_pend_reg <= 1'b1;
                if (!req_reg && !need_req_reg) begin
                  req_reg      <= 1'b1;
                  mem_addr_reg <= addr_next;
                end else begin
                  need_req_reg <= 1'b1;
                end
              end
            end
          end

          DATA: begin
            if (sck_fall) begin
              if (load_pend_reg) begin
                load_pend_reg <= 1'b0;
                pf_valid_reg  <= 1'b0;
                addr_reg      <= addr_reg + ADDR_W'(1);
                need_req_reg  <= 1'b1;
                if (pf_valid_reg) begin
                  tx_reg   <= pf_data_reg;
                  miso_reg <= pf_data_reg[7];
                end else if (ack_hit && !drop_reg) begin
                  tx_reg   <= mem.rdata;
                  miso_reg <= mem.rdata[7];
                end else begin
                  // Late data for this byte is discarded when it finally arrives.
                  tx_reg       <= 8'hFF;
                  miso_reg     <= 1'b1;
                  underrun_reg <= 1'b1;
                  if (req_reg && !ack_hit) begin
                    drop_reg <= 1'b1;
                  end
                end
              end else begin
                tx_reg   <= {tx_reg[6:0], 1'b0};
                miso_reg <= tx_reg[6];
              end
            end
            if (sck_rise) begin
              byte_bit_reg <= byte_bit_reg + 3'd1;
              if (byte_bit_reg == 3'd7) begin
                load_pend_reg <= 1'b1;
              end
            end
          end

          IGNORE: begin
            miso_reg <= 1'b0;
          end

          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign spi_miso = miso_reg;
  assign mem.req  = req_reg;
  assign mem.addr = mem_addr_reg;
  assign busy     = busy_reg;
  assign cmd_err  = cmd_err_reg;
  assign underrun = underrun_reg;

endmodule
